// File: rtl/cndm_proto_dma_desc_arb_pkg.sv
// Shared definitions for the prototype DMA descriptor channel: status codes and
// helpers that split an engine tag into {port index, requester tag}.
package cndm_proto_dma_pkg;

   typedef enum logic [3:0] {
      DMA_ERROR_NONE     = 4'd0,
      DMA_ERROR_TIMEOUT  = 4'd1,
      DMA_ERROR_POISONED = 4'd2,
      DMA_ERROR_UR       = 4'd3
   } dma_sts_e;

   function automatic logic [31:0] tag_port(input logic [31:0] tag, input int ports, input int tag_w);
      return tag >> (tag_w - $clog2(ports));
   endfunction

   function automatic logic [31:0] tag_local(input logic [31:0] tag, input int ports, input int tag_w);
      return tag & ((32'd1 << (tag_w - $clog2(ports))) - 32'd1);
   endfunction

endpackage

// File: rtl/cndm_proto_rr_arb.sv
// Round-robin arbiter: grants the first request at or after the pointer and
// advances the pointer past the winner whenever the grant is consumed (en).
module cndm_proto_rr_arb #(
   parameter  int PORTS = 4,
   localparam int IDX_W = $clog2(PORTS)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [PORTS-1:0] req,
   input  logic             en,
   output logic [PORTS-1:0] grant,
   output logic [IDX_W-1:0] grant_idx,
   output logic             grant_valid
);

   logic [IDX_W-1:0] ptr_q, ptr_d;
   int               cand;

   always_comb begin
      // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
      grant       = '0;
      grant_idx   = '0;
      grant_valid = 1'b0;
      cand        = 0;
      for (int i = 0; i < PORTS; i++) begin
         cand = (int'(ptr_q) + i) % PORTS;
         if (!grant_valid && req[cand]) begin
            grant_valid = 1'b1;
            grant_idx   = cand[IDX_W-1:0];
         end
      end
      if (grant_valid) grant[grant_idx] = 1'b1;

      ptr_d = ptr_q;
      if (en && grant_valid) ptr_d = (int'(grant_idx) == PORTS - 1) ? '0 : grant_idx + 1'b1;
   end

   // NOTE: sequential state is updated with non-blocking assignments only, so all flops see pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) ptr_q <= '0;
      else     ptr_q <= ptr_d;
   end

endmodule

// File: rtl/cndm_proto_dma_desc_arb.sv
// Shares one DMA descriptor request/status channel among PORTS requesters with
// round-robin grant, port-tagged requests, status routing and in-flight limits.
module cndm_proto_dma_desc_arb
   import cndm_proto_dma_pkg::*;
#(
   parameter  int PORTS           = 4,
   parameter  int ADDR_W          = 64,
   parameter  int SEL_W           = 4,
   parameter  int LEN_W           = 20,
   parameter  int TAG_W           = 8,
   parameter  int MAX_OUTSTANDING = 16,
   localparam int REQ_TAG_W       = TAG_W - $clog2(PORTS)
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [PORTS*ADDR_W-1:0]    s_req_addr,
   input  logic [PORTS*SEL_W-1:0]     s_req_sel,
   input  logic [PORTS*LEN_W-1:0]     s_req_len,
   input  logic [PORTS*REQ_TAG_W-1:0] s_req_tag,
   input  logic [PORTS-1:0]           s_req_valid,
   output logic [PORTS-1:0]           s_req_ready,
   output logic [ADDR_W-1:0]          m_req_addr,
   output logic [SEL_W-1:0]           m_req_sel,
   output logic [LEN_W-1:0]           m_req_len,
   output logic [TAG_W-1:0]           m_req_tag,
   output logic                       m_req_valid,
   input  logic                       m_req_ready,
   input  logic [TAG_W-1:0]           s_sts_tag,
   input  logic [3:0]                 s_sts_error,
   input  logic                       s_sts_valid,
   output logic [REQ_TAG_W-1:0]       m_sts_tag,
   output logic [3:0]                 m_sts_error,
   output logic [PORTS-1:0]           m_sts_valid,
   output logic [PORTS-1:0]           busy,
   output logic                       stat_err_unexp
);

   localparam int PORT_W = $clog2(PORTS);
   localparam int CNT_W  = $clog2(MAX_OUTSTANDING + 1);

   logic [CNT_W-1:0]     cnt_q [PORTS];
   logic [CNT_W-1:0]     cnt_d [PORTS];
   logic [PORTS-1:0]     eligible, arb_grant, busy_q, busy_d;
   logic [PORT_W-1:0]    arb_idx, sts_port;
   logic                 arb_valid, slot_free, arb_en, sts_in_range;
   logic [31:0]          sts_port_full, sts_local_full;

   logic [ADDR_W-1:0]    m_req_addr_q, m_req_addr_d;
   logic [SEL_W-1:0]     m_req_sel_q, m_req_sel_d;
   logic [LEN_W-1:0]     m_req_len_q, m_req_len_d;
   logic [TAG_W-1:0]     m_req_tag_q, m_req_tag_d;
   logic                 m_req_valid_q, m_req_valid_d;
   logic [REQ_TAG_W-1:0] m_sts_tag_q, m_sts_tag_d;
   logic [3:0]           m_sts_error_q, m_sts_error_d;
   logic [PORTS-1:0]     m_sts_valid_q, m_sts_valid_d;
   logic                 stat_err_unexp_q, stat_err_unexp_d;

   cndm_proto_rr_arb #(.PORTS(PORTS)) u_arb (
      .clk         (clk),
      .rst         (rst),
      .req         (eligible),
      .en          (arb_en),
      .grant       (arb_grant),
      .grant_idx   (arb_idx),
      .grant_valid (arb_valid)
   );

   always_comb begin
      for (int i = 0; i < PORTS; i++)
         eligible[i] = s_req_valid[i] && (cnt_q[i] < CNT_W'(MAX_OUTSTANDING));
      slot_free   = !m_req_valid_q || m_req_ready;
      arb_en      = slot_free && !rst;
      s_req_ready = arb_en ? arb_grant : '0;

      m_req_valid_d = m_req_valid_q;
      m_req_addr_d  = m_req_addr_q;
      m_req_sel_d   = m_req_sel_q;
      m_req_len_d   = m_req_len_q;
      m_req_tag_d   = m_req_tag_q;
      if (slot_free) begin
         m_req_valid_d = arb_en && arb_valid;
         if (arb_en && arb_valid) begin
            m_req_addr_d = s_req_addr[arb_idx*ADDR_W +: ADDR_W];
            m_req_sel_d  = s_req_sel[arb_idx*SEL_W +: SEL_W];
            m_req_len_d  = s_req_len[arb_idx*LEN_W +: LEN_W];
            m_req_tag_d  = {arb_idx, s_req_tag[arb_idx*REQ_TAG_W +: REQ_TAG_W]};
         end
      end
   end

   // Status for an idle port is still forwarded but flagged; the counter never underflows.
   always_comb begin
      sts_port_full  = tag_port(32'(s_sts_tag), PORTS, TAG_W);
      sts_local_full = tag_local(32'(s_sts_tag), PORTS, TAG_W);
      sts_port       = sts_port_full[PORT_W-1:0];
      sts_in_range   = sts_port_full < 32'(PORTS);

      m_sts_valid_d    = '0;
      m_sts_tag_d      = m_sts_tag_q;
      m_sts_error_d    = m_sts_error_q;
      stat_err_unexp_d = 1'b0;
      if (s_sts_valid) begin
         if (sts_in_range) begin
            m_sts_valid_d[sts_port] = 1'b1;
            m_sts_tag_d             = sts_local_full[REQ_TAG_W-1:0];
            m_sts_error_d           = s_sts_error;
            stat_err_unexp_d        = (cnt_q[sts_port] == '0);
         end else begin
            stat_err_unexp_d = 1'b1;
         end
      end

      for (int i = 0; i < PORTS; i++) begin
         cnt_d[i] = cnt_q[i];
         if (s_req_ready[i] && !(m_sts_valid_d[i] && cnt_q[i] != '0))
            cnt_d[i] = cnt_q[i] + 1'b1;
         else if (!s_req_ready[i] && m_sts_valid_d[i] && cnt_q[i] != '0)
            cnt_d[i] = cnt_q[i] - 1'b1;
         busy_d[i] = (cnt_d[i] != '0);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         m_req_valid_q    <= 1'b0;
         m_sts_valid_q    <= '0;
         stat_err_unexp_q <= 1'b0;
         busy_q           <= '0;
         for (int i = 0; i < PORTS; i++) cnt_q[i] <= '0;
      end else begin
         m_req_valid_q    <= m_req_valid_d;
         m_sts_valid_q    <= m_sts_valid_d;
         stat_err_unexp_q <= stat_err_unexp_d;
         busy_q           <= busy_d;
         for (int i = 0; i < PORTS; i++) cnt_q[i] <= cnt_d[i];
      end
   end

   // NOTE: payload registers are deliberately left out of reset; their valid flags qualify them.
   always_ff @(posedge clk) begin
      m_req_addr_q  <= m_req_addr_d;
      m_req_sel_q   <= m_req_sel_d;
      m_req_len_q   <= m_req_len_d;
      m_req_tag_q   <= m_req_tag_d;
      m_sts_tag_q   <= m_sts_tag_d;
      m_sts_error_q <= m_sts_error_d;
   end

   assign m_req_addr     = m_req_addr_q;
   assign m_req_sel      = m_req_sel_q;
   assign m_req_len      = m_req_len_q;
   assign m_req_tag      = m_req_tag_q;
   assign m_req_valid    = m_req_valid_q;
   assign m_sts_tag      = m_sts_tag_q;
   assign m_sts_error    = m_sts_error_q;
   assign m_sts_valid    = m_sts_valid_q;
   assign busy           = busy_q;
   assign stat_err_unexp = stat_err_unexp_q;

endmodule

// File: tb/tb_cndm_proto_dma_desc_arb.sv
// Bench for cndm_proto_dma_desc_arb: directed scenarios plus a random phase,
// checked against a per-port outstanding-count reference model.
module tb_cndm_proto_dma_desc_arb;
   import cndm_proto_dma_pkg::*;

   localparam int P    = 4;
   localparam int AW   = 64;
   localparam int SW   = 4;
   localparam int LW   = 20;
   localparam int TW   = 8;
   localparam int RTW  = 6;
   localparam int MAXO = 16;

   logic            clk = 1'b0;
   logic            rst;
   logic [P*AW-1:0] s_req_addr;
   logic [P*SW-1:0] s_req_sel;
   logic [P*LW-1:0] s_req_len;
   logic [P*RTW-1:0] s_req_tag;
   logic [P-1:0]    s_req_valid, s_req_ready;
   logic [AW-1:0]   m_req_addr;
   logic [SW-1:0]   m_req_sel;
   logic [LW-1:0]   m_req_len;
   logic [TW-1:0]   m_req_tag;
   logic            m_req_valid, m_req_ready;
   logic [TW-1:0]   s_sts_tag;
   logic [3:0]      s_sts_error;
   logic            s_sts_valid;
   logic [RTW-1:0]  m_sts_tag;
   logic [3:0]      m_sts_error;
   logic [P-1:0]    m_sts_valid, busy;
   logic            stat_err_unexp;

   // Three-port instance, used only for out-of-range status tags.
   logic [3*AW-1:0] d3_addr = '0;
   logic [3*SW-1:0] d3_sel = '0;
   logic [3*LW-1:0] d3_len = '0;
   logic [3*RTW-1:0] d3_tag = '0;
   logic [2:0]      d3_req_valid = '0, d3_req_ready, d3_sts_valid, d3_busy;
   logic [AW-1:0]   d3_m_addr;
   logic [SW-1:0]   d3_m_sel;
   logic [LW-1:0]   d3_m_len;
   logic [TW-1:0]   d3_m_tag, d3_s_sts_tag;
   logic            d3_m_valid, d3_s_sts_valid, d3_err;
   logic [RTW-1:0]  d3_m_sts_tag;
   logic [3:0]      d3_m_sts_error;

   always #5 clk = ~clk;

   cndm_proto_dma_desc_arb #(.PORTS(P), .ADDR_W(AW), .SEL_W(SW), .LEN_W(LW), .TAG_W(TW),
                             .MAX_OUTSTANDING(MAXO)) u_dut (
      .clk(clk), .rst(rst),
      .s_req_addr(s_req_addr), .s_req_sel(s_req_sel), .s_req_len(s_req_len), .s_req_tag(s_req_tag),
      .s_req_valid(s_req_valid), .s_req_ready(s_req_ready),
      .m_req_addr(m_req_addr), .m_req_sel(m_req_sel), .m_req_len(m_req_len), .m_req_tag(m_req_tag),
      .m_req_valid(m_req_valid), .m_req_ready(m_req_ready),
      .s_sts_tag(s_sts_tag), .s_sts_error(s_sts_error), .s_sts_valid(s_sts_valid),
      .m_sts_tag(m_sts_tag), .m_sts_error(m_sts_error), .m_sts_valid(m_sts_valid),
      .busy(busy), .stat_err_unexp(stat_err_unexp)
   );

   cndm_proto_dma_desc_arb #(.PORTS(3), .ADDR_W(AW), .SEL_W(SW), .LEN_W(LW), .TAG_W(TW),
                             .MAX_OUTSTANDING(MAXO)) u_dut3 (
      .clk(clk), .rst(rst),
      .s_req_addr(d3_addr), .s_req_sel(d3_sel), .s_req_len(d3_len), .s_req_tag(d3_tag),
      .s_req_valid(d3_req_valid), .s_req_ready(d3_req_ready),
      .m_req_addr(d3_m_addr), .m_req_sel(d3_m_sel), .m_req_len(d3_m_len), .m_req_tag(d3_m_tag),
      .m_req_valid(d3_m_valid), .m_req_ready(1'b1),
      .s_sts_tag(d3_s_sts_tag), .s_sts_error(4'd0), .s_sts_valid(d3_s_sts_valid),
      .m_sts_tag(d3_m_sts_tag), .m_sts_error(d3_m_sts_error), .m_sts_valid(d3_sts_valid),
      .busy(d3_busy), .stat_err_unexp(d3_err)
   );

   int n_asserts = 0;
   int n_fail    = 0;

   // Reference model: outstanding count per port, next-priority port, expected outputs.
   int           cnt [P];
   int           ptr;
   bit           e_mv;
   logic [AW-1:0] e_addr;
   logic [SW-1:0] e_sel;
   logic [LW-1:0] e_len;
   logic [TW-1:0] e_tag;
   logic [P-1:0]  e_sts_v;
   logic [RTW-1:0] e_sts_tag;
   logic [3:0]    e_sts_err;
   bit            e_err;

   task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
      n_asserts++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h, expected 0x%0h", name, obs, exp);
      end
   endtask

   task automatic rand_fields();
      for (int i = 0; i < P; i++) begin
         s_req_addr[i*AW +: AW]  = {$urandom, $urandom};
         s_req_sel[i*SW +: SW]   = SW'($urandom);
         s_req_len[i*LW +: LW]   = LW'($urandom);
         s_req_tag[i*RTW +: RTW] = RTW'($urandom);
      end
   endtask

   // One clock: check the combinational grant, advance the model, check registered outputs.
   task automatic cycle();
      int g, p;
      bit free;
      logic [P-1:0] exp_rdy, exp_busy;
      #1;
      g = -1;
      free = !e_mv || m_req_ready;
      if (!rst && free)
         for (int k = 0; k < P; k++)
            if (g < 0 && s_req_valid[(ptr + k) % P] && cnt[(ptr + k) % P] < MAXO) g = (ptr + k) % P;
      exp_rdy = (g >= 0) ? P'(1 << g) : '0;
      chk("s_req_ready", 64'(s_req_ready), 64'(exp_rdy));

      if (rst) begin
         for (int i = 0; i < P; i++) cnt[i] = 0;
         ptr = 0; e_mv = 0; e_sts_v = '0; e_err = 0;
      end else begin
         e_sts_v = '0;
         e_err   = 0;
         if (s_sts_valid) begin
            p = int'(s_sts_tag) / (1 << RTW);
            e_sts_v[p] = 1'b1;
            e_sts_tag  = s_sts_tag[RTW-1:0];
            e_sts_err  = s_sts_error;
            if (cnt[p] == 0) e_err = 1;
            else cnt[p]--;
         end
         if (free) begin
            e_mv = (g >= 0);
            if (g >= 0) begin
               e_addr = s_req_addr[g*AW +: AW];
               e_sel  = s_req_sel[g*SW +: SW];
               e_len  = s_req_len[g*LW +: LW];
               e_tag  = TW'(g * (1 << RTW)) | TW'(s_req_tag[g*RTW +: RTW]);
               ptr    = (g + 1) % P;
               cnt[g]++;
            end
         end
      end

      @(posedge clk);
      #1;
      chk("m_req_valid", 64'(m_req_valid), 64'(e_mv));
      if (e_mv) begin
         chk("m_req_addr", m_req_addr, e_addr);
         chk("m_req_sel", 64'(m_req_sel), 64'(e_sel));
         chk("m_req_len", 64'(m_req_len), 64'(e_len));
         chk("m_req_tag", 64'(m_req_tag), 64'(e_tag));
      end
      chk("m_sts_valid", 64'(m_sts_valid), 64'(e_sts_v));
      if (e_sts_v != '0) begin
         chk("m_sts_tag", 64'(m_sts_tag), 64'(e_sts_tag));
         chk("m_sts_error", 64'(m_sts_error), 64'(e_sts_err));
      end
      for (int i = 0; i < P; i++) exp_busy[i] = (cnt[i] != 0);
      chk("busy", 64'(busy), 64'(exp_busy));
      chk("stat_err_unexp", 64'(stat_err_unexp), 64'(e_err));
   endtask

   task automatic do_reset();
      rst = 1'b1; s_req_valid = '0; s_sts_valid = 1'b0;
      cycle();
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1; s_req_valid = '0; m_req_ready = 1'b0;
      s_sts_tag = '0; s_sts_error = '0; s_sts_valid = 1'b0;
      d3_s_sts_tag = '0; d3_s_sts_valid = 1'b0;
      for (int i = 0; i < P; i++) cnt[i] = 0;
      ptr = 0; e_mv = 0; e_sts_v = '0; e_err = 0;
      rand_fields();
      @(posedge clk); #1;

      // Reset holds every output low even with all requests pending.
      s_req_valid = '1;
      for (int i = 0; i < 3; i++) cycle();
      rst = 1'b0; s_req_valid = '0; m_req_ready = 1'b1;
      cycle();

      // Round robin over all ports with the engine always ready.
      s_req_valid = '1;
      for (int i = 0; i < 5; i++) begin rand_fields(); cycle(); end

      // Engine stalls: descriptor held while the requester inputs keep changing.
      m_req_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin rand_fields(); cycle(); end
      m_req_ready = 1'b1;
      rand_fields(); cycle();

      // Port 1 saturates its in-flight limit, then one status frees a slot.
      do_reset();
      s_req_valid = 4'b0010; m_req_ready = 1'b1;
      for (int i = 0; i < 18; i++) begin rand_fields(); cycle(); end
      chk("busy1_at_limit", 64'(busy[1]), 64'd1);
      s_sts_valid = 1'b1; s_sts_tag = 8'h45; s_sts_error = DMA_ERROR_TIMEOUT;
      cycle();
      chk("sts_valid_0x45", 64'(m_sts_valid), 64'h2);
      chk("sts_tag_0x45", 64'(m_sts_tag), 64'h05);
      s_sts_valid = 1'b0;
      cycle();

      // Port 2: grant and status together, then drain to an unexpected status.
      do_reset();
      s_req_valid = 4'b0100;
      for (int i = 0; i < 3; i++) begin rand_fields(); cycle(); end
      s_sts_valid = 1'b1; s_sts_tag = 8'h80 | 8'($urandom_range(0, 63)); s_sts_error = DMA_ERROR_NONE;
      cycle();
      s_req_valid = '0;
      for (int i = 0; i < 4; i++) begin
         s_sts_tag = 8'h81; s_sts_error = DMA_ERROR_POISONED;
         cycle();
      end
      chk("unexp_port2_strobe", 64'(m_sts_valid), 64'h4);
      chk("unexp_port2_err", 64'(stat_err_unexp), 64'd1);
      s_sts_valid = 1'b0;
      cycle();

      // Random traffic, engine backpressure and statuses to any port.
      do_reset();
      for (int i = 0; i < 400; i++) begin
         rand_fields();
         s_req_valid = P'($urandom);
         m_req_ready = ($urandom_range(0, 3) != 0);
         s_sts_valid = $urandom_range(0, 1) == 1;
         s_sts_tag   = TW'($urandom);
         s_sts_error = 4'($urandom_range(0, 3));
         cycle();
      end
      s_sts_valid = 1'b0;

      // Reset with five operations in flight and a descriptor pending.
      do_reset();
      s_req_valid = '1; m_req_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin rand_fields(); cycle(); end
      m_req_ready = 1'b0; rst = 1'b1;
      cycle();
      chk("rst_mid_valid", 64'(m_req_valid), 64'd0);
      chk("rst_mid_busy", 64'(busy), 64'd0);
      rst = 1'b0; m_req_ready = 1'b1; rand_fields();
      #1 chk("post_rst_grant", 64'(s_req_ready), 64'h1);
      cycle();
      s_req_valid = '0; s_sts_valid = 1'b1; s_sts_tag = 8'h41;
      cycle();
      s_sts_valid = 1'b0;
      cycle();

      // Three-port instance: port field 3 has no requester.
      d3_s_sts_valid = 1'b1; d3_s_sts_tag = 8'hC1;
      @(posedge clk); #1;
      d3_s_sts_valid = 1'b0;
      chk("p3_drop_strobe", 64'(d3_sts_valid), 64'd0);
      chk("p3_drop_err", 64'(d3_err), 64'd1);
      @(posedge clk); #1;
      chk("p3_err_cleared", 64'(d3_err), 64'd0);
      d3_s_sts_valid = 1'b1; d3_s_sts_tag = 8'h81;
      @(posedge clk); #1;
      d3_s_sts_valid = 1'b0;
      chk("p3_fwd_strobe", 64'(d3_sts_valid), 64'h4);
      chk("p3_fwd_tag", 64'(d3_m_sts_tag), 64'h01);
      chk("p3_fwd_err", 64'(d3_err), 64'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

endmodule

// File: doc/cndm_proto_dma_desc_arb.md
Name: cndm_proto_dma_desc_arb

Overview:
Shares the single DMA read (or write) descriptor request/status channel of the PCIe DMA engine between PORTS requesters, e.g. per-port TX and RX queue managers.
- Arbitrates requests round-robin.
- Embeds the requester index in the upper bits of the outgoing tag.
- Routes returning status back to the originating requester.
- Enforces a per-requester outstanding-operation limit.
- Sits between the port datapaths and the DMA interface, in the PCIe clock domain.

Parameters:
PORTS, 4, number of requesters (≥2)
ADDR_W, 64, descriptor address width
SEL_W, 4, RAM select width
LEN_W, 20, transfer length width
TAG_W, 8, DMA engine tag width
MAX_OUTSTANDING, 16, per-port in-flight limit (1..255)
REQ_TAG_W, TAG_W-$clog2(PORTS) (localparam), requester tag width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
s_req_addr  in  PORTS*ADDR_W  per-port descriptor address
s_req_sel  in  PORTS*SEL_W  per-port RAM select
s_req_len  in  PORTS*LEN_W  per-port length
s_req_tag  in  PORTS*REQ_TAG_W  per-port requester tag
s_req_valid  in  PORTS  request valid
s_req_ready  out  PORTS  request accepted (one-hot or zero)
m_req_addr  out  ADDR_W  to DMA engine
m_req_sel  out  SEL_W  to DMA engine
m_req_len  out  LEN_W  to DMA engine
m_req_tag  out  TAG_W  {port index, requester tag}
m_req_valid  out  1  descriptor valid
m_req_ready  in  1  DMA engine accept
s_sts_tag  in  TAG_W  status tag from DMA engine
s_sts_error  in  4  status code
s_sts_valid  in  1  status valid (no backpressure)
m_sts_tag  out  REQ_TAG_W  shared status tag to requesters
m_sts_error  out  4  shared status code
m_sts_valid  out  PORTS  one-hot status strobe
busy  out  PORTS  port has operations in flight
stat_err_unexp  out  1  one-cycle pulse on unexpected status

Behaviour:
Reset:
- m_req_valid=0, s_req_ready=0, m_sts_valid=0, busy=0, stat_err_unexp=0.
- All counters=0; round-robin pointer=0, so port 0 has first priority.
- Reset mid-operation discards any held descriptor. Late statuses are routed normally: counters are already 0, so each also pulses stat_err_unexp.

Request path:
- Single output register stage. A slot is free when m_req_valid==0 or m_req_ready==1.
- Eligible port: s_req_valid[i]=1 and count[i] < MAX_OUTSTANDING.
- When the slot is free and any port is eligible, grant the first eligible port at or after the pointer, wrapping modulo PORTS.
- s_req_ready[grant] is asserted combinationally in that cycle. The descriptor is registered and m_req_valid=1 on the next edge.
- After a grant, pointer = grant+1 mod PORTS.
- Latency: request to m_req_valid is 1 cycle. Back-to-back grants on consecutive cycles are allowed when m_req_ready is held high.
- m_req_* stays stable while m_req_valid=1 and m_req_ready=0.
- m_req_tag = {grant index zero-extended to $clog2(PORTS) bits, s_req_tag}.
- count[i] increments on grant.

Status path:
- Registered, 1-cycle latency.
- Port p = s_sts_tag[TAG_W-1:REQ_TAG_W].
- If p < PORTS: m_sts_valid[p]=1; m_sts_tag=s_sts_tag[REQ_TAG_W-1:0]; m_sts_error=s_sts_error; count[p] decrements.
- If p ≥ PORTS: status dropped, stat_err_unexp pulses.
- If count[p]==0: status is still forwarded, count stays 0 (no underflow), stat_err_unexp pulses.
- Grant and status to the same port in one cycle: count unchanged.
- busy[i] = (count[i] != 0), registered.
- Counter width: $clog2(MAX_OUTSTANDING+1).

Decomposition:
- Package cndm_proto_dma_pkg holds:
  - DMA status code constants (OK=0, timeout, poisoned, unsupported-request).
  - Functions tag_port() and tag_local() that split tags given PORTS and TAG_W.
- Natural sub-module: cndm_proto_rr_arb, a parameterised round-robin arbiter. Inputs: request vector, enable. Outputs: one-hot grant and grant index, with pointer update on enable.

Test Plan:
- All 4 ports valid continuously, m_req_ready=1 → grants 0,1,2,3,0 on consecutive cycles; tags 0x00|t0, 0x40|t1, 0x80|t2, 0xC0|t3.
- m_req_ready=0 for 5 cycles with descriptor held → m_req_* stable; no s_req_ready asserted; next grant is taken on the ready cycle.
- Port 1 issues 16 requests, MAX_OUTSTANDING=16, no status → 17th not accepted and busy[1]=1. Status tag 0x45 → m_sts_valid=0010, m_sts_tag=0x05; the next cycle port 1 is grantable again.
- Grant to port 2 in the same cycle as status for port 2 at count=3 → count stays 3; m_sts_valid[2] pulses.
- Status tag 0x81 with count[2]=0 → forwarded to port 2, stat_err_unexp=1 for 1 cycle. With PORTS=3, tag 0xC1 → dropped, stat_err_unexp=1.
- Assert rst while 5 operations are in flight and m_req_valid=1 → m_req_valid=0 and busy=0 next cycle; first post-reset grant goes to port 0.
